// File: rtl/tap_ctrl_ir.sv
// IEEE 1149.1 TAP controller: 16-state FSM, one-hot state strobes and the
// instruction register (posedge shift stage, negedge update/latch and TDO).
module tap_ctrl_ir #(
  parameter int unsigned             IR_WIDTH         = 4,
  parameter logic [IR_WIDTH-1:0]     IR_RESET_VALUE   = 4'h7,
  parameter logic [IR_WIDTH-1:0]     IR_CAPTURE_VALUE = 4'b0001
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic [3:0]          STATE,
  output logic                TLR,
  output logic                RTI,
  output logic                CAPTURE_DR,
  output logic                SHIFT_DR,
  output logic                UPDATE_DR,
  output logic                CAPTURE_IR,
  output logic                SHIFT_IR,
  output logic                UPDATE_IR,
  output logic [IR_WIDTH-1:0] LATCH_IR,
  output logic                IR_TDO,
  output logic                TDO_EN
);

  typedef enum logic [3:0] {
    S_TLR   = 4'hF, S_RTI   = 4'hC,
    S_SELDR = 4'h7, S_CAPDR = 4'h6, S_SHDR  = 4'h2, S_EX1DR = 4'h1,
    S_PAUDR = 4'h3, S_EX2DR = 4'h0, S_UPDDR = 4'h5,
    S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR  = 4'hA, S_EX1IR = 4'h9,
    S_PAUIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD
  } tap_state_e;

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] latch_q, latch_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_TLR:   state_d = TMS ? S_TLR   : S_RTI;
      S_RTI:   state_d = TMS ? S_SELDR : S_RTI;
      S_SELDR: state_d = TMS ? S_SELIR : S_CAPDR;
      S_CAPDR: state_d = TMS ? S_EX1DR : S_SHDR;
      S_SHDR:  state_d = TMS ? S_EX1DR : S_SHDR;
      S_EX1DR: state_d = TMS ? S_UPDDR : S_PAUDR;
      S_PAUDR: state_d = TMS ? S_EX2DR : S_PAUDR;
      S_EX2DR: state_d = TMS ? S_UPDDR : S_SHDR;
      S_UPDDR: state_d = TMS ? S_SELDR : S_RTI;
      S_SELIR: state_d = TMS ? S_TLR   : S_CAPIR;
      S_CAPIR: state_d = TMS ? S_EX1IR : S_SHIR;
      S_SHIR:  state_d = TMS ? S_EX1IR : S_SHIR;
      S_EX1IR: state_d = TMS ? S_UPDIR : S_PAUIR;
      S_PAUIR: state_d = TMS ? S_EX2IR : S_PAUIR;
      S_EX2IR: state_d = TMS ? S_UPDIR : S_SHIR;
      S_UPDIR: state_d = TMS ? S_SELDR : S_RTI;
      default: state_d = S_TLR;
    endcase
  end

  // Shift stage acts on the posedge leaving Capture-IR / Shift-IR.
  always_comb begin
    ir_d = ir_q;
    unique case (state_q)
      S_TLR, S_CAPIR: ir_d = IR_CAPTURE_VALUE;
      S_SHIR:         ir_d = {TDI, ir_q[IR_WIDTH-1:1]};
      default:        ir_d = ir_q;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q <= S_TLR;
      ir_q    <= IR_CAPTURE_VALUE;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Negedge side: instruction and TDO settle half a cycle before the next
  // posedge so downstream logic sees stable values.
  always_comb begin
    latch_d  = latch_q;
    tdo_d    = tdo_q;
    tdo_en_d = (state_q == S_SHDR) || (state_q == S_SHIR);
    if (state_q == S_UPDIR) latch_d = ir_q;
    if (state_q == S_TLR)   latch_d = IR_RESET_VALUE;
    if (state_q == S_SHIR)  tdo_d   = ir_q[0];
  end

  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      latch_q  <= IR_RESET_VALUE;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      latch_q  <= latch_d;
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign STATE      = state_q;
  assign TLR        = (state_q == S_TLR);
  assign RTI        = (state_q == S_RTI);
  assign CAPTURE_DR = (state_q == S_CAPDR);
  assign SHIFT_DR   = (state_q == S_SHDR);
  assign UPDATE_DR  = (state_q == S_UPDDR);
  assign CAPTURE_IR = (state_q == S_CAPIR);
  assign SHIFT_IR   = (state_q == S_SHIR);
  assign UPDATE_IR  = (state_q == S_UPDIR);
  assign LATCH_IR   = latch_q;
  assign IR_TDO     = tdo_q;
  assign TDO_EN     = tdo_en_q;

endmodule

// File: tb/tb_tap_ctrl_ir.sv
// Directed bench for tap_ctrl_ir: TMS/TDI walks with hand-derived expectations.
module tb_tap_ctrl_ir;
  logic       TCK = 1'b0;
  logic       TRST = 1'b0;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic [3:0] STATE;
  logic       TLR, RTI, CAPTURE_DR, SHIFT_DR, UPDATE_DR;
  logic       CAPTURE_IR, SHIFT_IR, UPDATE_IR;
  logic [3:0] LATCH_IR;
  logic       IR_TDO, TDO_EN;

  int n_chk = 0;
  int n_err = 0;

  tap_ctrl_ir dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
    .STATE(STATE), .TLR(TLR), .RTI(RTI),
    .CAPTURE_DR(CAPTURE_DR), .SHIFT_DR(SHIFT_DR), .UPDATE_DR(UPDATE_DR),
    .CAPTURE_IR(CAPTURE_IR), .SHIFT_IR(SHIFT_IR), .UPDATE_IR(UPDATE_IR),
    .LATCH_IR(LATCH_IR), .IR_TDO(IR_TDO), .TDO_EN(TDO_EN)
  );

  always #5 TCK = ~TCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full TCK cycle; returns 1 time unit after the negedge.
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  int cap_n, sh_n, upd_n, en_n;

  initial begin
    // reset state, with TCK toggling
    @(negedge TCK); #1;
    chk("rst_state", 32'(STATE), 32'hF);
    chk("rst_tlr",   32'(TLR), 32'd1);
    chk("rst_rti",   32'(RTI), 32'd0);
    chk("rst_latch", 32'(LATCH_IR), 32'h7);
    chk("rst_tdoen", 32'(TDO_EN), 32'd0);
    chk("rst_tdo",   32'(IR_TDO), 32'd0);
    TRST = 1'b1;

    // TLR -> RTI, then five TMS=1 back to TLR
    tick(1'b0, 1'b0);
    chk("rti_state", 32'(STATE), 32'hC);
    chk("rti_strobe", 32'(RTI), 32'd1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk("rti5_state", 32'(STATE), 32'hF);

    // DR path: RTI SelDR CapDR ShDR x3 Ex1DR UpdDR RTI
    tick(1'b0, 1'b0);
    cap_n = 0; sh_n = 0; upd_n = 0; en_n = 0;
    begin
      logic tms_seq [8];
      tms_seq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
        tick(tms_seq[i], 1'b1);
        cap_n += int'(CAPTURE_DR);
        sh_n  += int'(SHIFT_DR);
        upd_n += int'(UPDATE_DR);
        en_n  += int'(TDO_EN);
        if (i == 1) chk("dr_capstate", 32'(STATE), 32'h6);
        if (i == 4) chk("dr_shen", 32'(TDO_EN), 32'd1);
        if (i == 5) chk("dr_ex1en", 32'(TDO_EN), 32'd0);
      end
    end
    chk("dr_cap_cycles", 32'(cap_n), 32'd1);
    chk("dr_sh_cycles",  32'(sh_n),  32'd3);
    chk("dr_upd_cycles", 32'(upd_n), 32'd1);
    chk("dr_en_cycles",  32'(en_n),  32'd3);
    chk("dr_latch",      32'(LATCH_IR), 32'h7);
    chk("dr_end_state",  32'(STATE), 32'hC);

    // From Shift-DR, five TMS=1 to TLR
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    chk("shdr_state", 32'(STATE), 32'h2);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk("shdr5_state", 32'(STATE), 32'hF);

    // IR load 4'hF: TMS 0,1,1,0,0 -> ShIR
    tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("capir_strobe", 32'(CAPTURE_IR), 32'd1);
    tick(1'b0, 1'b0);
    chk("shir_state", 32'(STATE), 32'hA);
    chk("shir_en", 32'(TDO_EN), 32'd1);
    tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b1, 1'b1);
    chk("ldF_ex1", 32'(STATE), 32'h9);
    chk("ldF_ex1_latch", 32'(LATCH_IR), 32'h7);
    TMS = 1'b1;
    @(posedge TCK); #1;
    chk("ldF_upd_state", 32'(STATE), 32'hD);
    chk("ldF_upd_strobe", 32'(UPDATE_IR), 32'd1);
    chk("ldF_before_neg", 32'(LATCH_IR), 32'h7);
    @(negedge TCK); #1;
    chk("ldF_latch", 32'(LATCH_IR), 32'hF);
    tick(1'b0, 1'b0);
    chk("ldF_hold", 32'(LATCH_IR), 32'hF);

    // Capture check: IR_TDO 1,0,0,0; TDI 1,0,1 then 1 -> latch 4'hD
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    chk("cap_tdo0", 32'(IR_TDO), 32'd1);
    tick(1'b0, 1'b1);
    chk("cap_tdo1", 32'(IR_TDO), 32'd0);
    tick(1'b0, 1'b0);
    chk("cap_tdo2", 32'(IR_TDO), 32'd0);
    tick(1'b0, 1'b1);
    chk("cap_tdo3", 32'(IR_TDO), 32'd0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    chk("cap_latch", 32'(LATCH_IR), 32'hD);

    // Pause resume: 4'b1010 LSB first, split by Pause-IR
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b0); tick(1'b1, 1'b1);
    tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    chk("pau_state", 32'(STATE), 32'hB);
    chk("pau_latch", 32'(LATCH_IR), 32'hD);
    chk("pau_tdoen", 32'(TDO_EN), 32'd0);
    tick(1'b1, 1'b0);
    chk("ex2_state", 32'(STATE), 32'h8);
    tick(1'b0, 1'b0);
    chk("resume_state", 32'(STATE), 32'hA);
    tick(1'b0, 1'b0); tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    chk("pau_resume_latch", 32'(LATCH_IR), 32'hA);

    // From Pause-IR, five TMS=1 to TLR
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("pauir_state", 32'(STATE), 32'hB);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk("pauir5_state", 32'(STATE), 32'hF);
    chk("pauir5_latch", 32'(LATCH_IR), 32'h7);

    // Load 4'h3, then TRST mid-Shift-IR
    tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b0); tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("ld3_latch", 32'(LATCH_IR), 32'h3);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("pre_trst_en", 32'(TDO_EN), 32'd1);
    TRST = 1'b0;
    #1;
    chk("trst_state", 32'(STATE), 32'hF);
    chk("trst_tlr",   32'(TLR), 32'd1);
    chk("trst_shir",  32'(SHIFT_IR), 32'd0);
    chk("trst_latch", 32'(LATCH_IR), 32'h7);
    chk("trst_tdoen", 32'(TDO_EN), 32'd0);
    chk("trst_tdo",   32'(IR_TDO), 32'd0);
    #1;
    TRST = 1'b1;

    // Partially shifted IR discarded: fresh capture comes out first
    tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("post_trst_tdo", 32'(IR_TDO), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tap_ctrl_ir.md
Name: tap_ctrl_ir

Overview:
- IEEE 1149.1 TAP controller with an integrated instruction register.
- Implements the 16-state TAP state machine clocked by TCK and steered by TMS.
- Decodes the current state into the one-hot control strobes (TLR, CAPTURE_DR, SHIFT_DR, ...) consumed by the DR-side blocks.
- Owns the IR shift/update path that produces LATCH_IR for the bypass/boundary/IDCODE data registers.

Parameters:
IR_WIDTH, 4, instruction register width in bits
IR_RESET_VALUE, 4'h7, LATCH_IR value forced in Test-Logic-Reset (IDCODE)
IR_CAPTURE_VALUE, 4'b0001, value loaded into IR shift stage in Capture-IR (LSBs must be 2'b01)

Ports:
TCK  input  1  test clock
TRST  input  1  test reset, asynchronous, active-low
TMS  input  1  test mode select, sampled on posedge TCK
TDI  input  1  serial data in, shifted into IR on posedge TCK in Shift-IR
STATE  output  4  current TAP state encoding (debug/observability)
TLR  output  1  high while in Test-Logic-Reset
RTI  output  1  high while in Run-Test/Idle
CAPTURE_DR  output  1  high while in Capture-DR
SHIFT_DR  output  1  high while in Shift-DR
UPDATE_DR  output  1  high while in Update-DR
CAPTURE_IR  output  1  high while in Capture-IR
SHIFT_IR  output  1  high while in Shift-IR
UPDATE_IR  output  1  high while in Update-IR
LATCH_IR  output  IR_WIDTH  active instruction
IR_TDO  output  1  IR serial out, registered on negedge TCK
TDO_EN  output  1  TDO driver enable, registered on negedge TCK

Behaviour:
- Reset (TRST low, async):
  - STATE = Test-Logic-Reset (TLR=1, all other strobes 0).
  - IR shift stage = IR_CAPTURE_VALUE.
  - LATCH_IR = IR_RESET_VALUE.
  - IR_TDO = 0, TDO_EN = 0.
- State encodings (hex):
  - TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5.
  - SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D.
- Transitions on posedge TCK (next state given as TMS=0 / TMS=1):
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauDR / UpdDR
  - PauDR: PauDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - CapIR: ShIR / Ex1IR
  - ShIR: ShIR / Ex1IR
  - Ex1IR: PauIR / UpdIR
  - PauIR: PauIR / Ex2IR
  - Ex2IR: ShIR / UpdIR
  - UpdIR: RTI / SelDR
- Strobes:
  - Moore decode of the state register, no extra latency.
  - A strobe is high for exactly the TCK cycle(s) the FSM occupies that state.
  - Downstream blocks act on the posedge that leaves the state.
- IR shift stage (posedge TCK):
  - Capture-IR: load IR_CAPTURE_VALUE.
  - Shift-IR: {TDI, ir[IR_WIDTH-1:1]} (LSB first out).
  - TLR: reload IR_CAPTURE_VALUE.
  - Otherwise: hold.
- LATCH_IR (negedge TCK):
  - Update-IR: LATCH_IR <= IR shift stage.
  - TLR: LATCH_IR <= IR_RESET_VALUE.
  - Otherwise: hold.
  - LATCH_IR never changes during a DR scan or during Shift-IR/Pause-IR.
- IR_TDO (negedge TCK): <= ir[0] while in Shift-IR; else holds its last value.
- TDO_EN (negedge TCK): <= (state==ShDR || state==ShIR); otherwise 0.
- Pause-IR/Exit2-IR: IR contents held; shifting resumes without loss on return to Shift-IR.
- From any state, five consecutive posedges with TMS=1 reach TLR.
- TRST mid-scan: immediate async return to reset values. The partially shifted IR is discarded; LATCH_IR = IR_RESET_VALUE.
- TRST deassertion is synchronised by the environment; the block imposes no extra recovery cycles.

Test Plan:
- TRST pulse low mid-Shift-IR -> STATE=F, TLR=1, LATCH_IR=4'h7, TDO_EN=0 immediately, no TCK edge required.
- From RTI, TMS=1,1,1,1,1 -> STATE=F after 5th posedge. Repeat from ShDR and PauIR -> same result.
- IR load 4'hF: TMS 0,1,1,0,0 to ShIR, shift TDI=1 x4 (TMS=1 on last), TMS=1 to UpdIR -> LATCH_IR=4'hF at negedge in UpdIR, not before.
- Capture check: enter ShIR, observe IR_TDO over 4 negedges -> 1,0,0,0 (IR_CAPTURE_VALUE LSB first).
- Pause resume: shift 2 bits of 4'b1010, go Ex1IR->PauIR (3 cycles)->Ex2IR->ShIR, shift remaining 2 bits, update -> LATCH_IR=4'hA.
- DR path: RTI->SelDR->CapDR->ShDR x3->Ex1DR->UpdDR -> CAPTURE_DR high 1 cycle, SHIFT_DR high 3 cycles, UPDATE_DR high 1 cycle, TDO_EN high only during ShDR, LATCH_IR unchanged.
